// File: rtl/vcve2_pkg.sv
// Shared types for the vector register file port arbiter.
package vcve2_pkg;

    localparam int unsigned VrfNumPorts = 2;

    typedef enum logic {
        ARB_FREE   = 1'b0,
        ARB_LOCKED = 1'b1
    } vrf_arb_state_t;

    // The port that is not `port` (two-port arbiter).
    function automatic logic vrf_other_port(input logic port);
        return ~port;
    endfunction

endpackage

// File: rtl/vrf_port_arbiter.sv
// Round-robin arbiter sharing the single-port VRF RAM between the operand
// sequencer (port 0) and the load/store unit (port 1), with burst locking.
module vrf_port_arbiter
    import vcve2_pkg::*;
#(
    parameter int unsigned VLEN      = 128,
    parameter int unsigned AddrWidth = 5,
    parameter int unsigned MaxLock   = 16
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [VrfNumPorts-1:0]               req_i,
    input  logic [VrfNumPorts-1:0]               we_i,
    input  logic [VrfNumPorts-1:0]               lock_i,
    input  logic [VrfNumPorts*AddrWidth-1:0]     addr_i,
    input  logic [VrfNumPorts*VLEN-1:0]          wdata_i,
    output logic [VrfNumPorts-1:0]               gnt_o,
    output logic [VrfNumPorts-1:0]               rvalid_o,
    output logic [VLEN-1:0]                      rdata_o,
    output logic                                 lock_abort_o,
    output logic                                 ram_req_o,
    output logic                                 ram_we_o,
    output logic [AddrWidth-1:0]                 ram_addr_o,
    output logic [VLEN-1:0]                      ram_wdata_o,
    input  logic [VLEN-1:0]                      ram_rdata_i
);

    localparam int unsigned CntW = (MaxLock == 0) ? 1 : $clog2(MaxLock + 1);
    localparam logic [CntW-1:0] CntMax = (MaxLock == 0) ? {CntW{1'b1}} : CntW'(MaxLock);

    vrf_arb_state_t          state_q, state_d;
    logic                    rr_q, rr_d;
    logic                    owner_q, owner_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [VrfNumPorts-1:0]  rvalid_q;

    logic [VrfNumPorts-1:0]  gnt;
    logic                    abort;
    logic                    free_arb;
    logic                    pref;
    logic                    winner;
    logic                    other;

    // Arbitration state, round-robin pointer, lock owner and lock counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ARB_FREE;
            rr_q    <= 1'b0;
            owner_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    // Grant decision and next-state; a released lock re-arbitrates in the same cycle.
    always_comb begin
        gnt      = '0;
        abort    = 1'b0;
        free_arb = 1'b0;
        pref     = rr_q;
        winner   = 1'b0;
        other    = vrf_other_port(owner_q);
        state_d  = state_q;
        rr_d     = rr_q;
        owner_d  = owner_q;
        cnt_d    = cnt_q;

        case (state_q)
            ARB_FREE: begin
                free_arb = 1'b1;
            end
            ARB_LOCKED: begin
                if (!req_i[owner_q]) begin
                    free_arb = 1'b1;
                    pref     = other;
                    state_d  = ARB_FREE;
                end else if ((MaxLock != 0) && (cnt_q == CntMax) && req_i[other]) begin
                    gnt[other] = 1'b1;
                    abort      = 1'b1;
                    rr_d       = owner_q;
                    state_d    = ARB_FREE;
                end else begin
                    gnt[owner_q] = 1'b1;
                    if (lock_i[owner_q]) begin
                        if (req_i[other] && (cnt_q != CntMax)) begin
                            cnt_d = cnt_q + CntW'(1);
                        end
                    end else begin
                        rr_d    = other;
                        state_d = ARB_FREE;
                    end
                end
            end
            default: begin
                state_d = ARB_FREE;
            end
        endcase

        if (free_arb && (req_i != '0)) begin
            winner      = (req_i == 2'b11) ? pref : req_i[1];
            gnt[winner] = 1'b1;
            if (lock_i[winner]) begin
                owner_d = winner;
                cnt_d   = '0;
                state_d = ARB_LOCKED;
            end else begin
                rr_d    = vrf_other_port(winner);
                state_d = ARB_FREE;
            end
        end
    end

    // One-cycle read latency: remember which port was granted a read.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q <= '0;
        end else begin
            rvalid_q <= gnt & ~we_i;
        end
    end

    // RAM-side mux from the granted port; address and data are zero when idle.
    always_comb begin
        ram_req_o   = |gnt;
        ram_we_o    = 1'b0;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        if (gnt[1]) begin
            ram_we_o    = we_i[1];
            ram_addr_o  = addr_i[2*AddrWidth-1:AddrWidth];
            ram_wdata_o = wdata_i[2*VLEN-1:VLEN];
        end else if (gnt[0]) begin
            ram_we_o    = we_i[0];
            ram_addr_o  = addr_i[AddrWidth-1:0];
            ram_wdata_o = wdata_i[VLEN-1:0];
        end
    end

    assign gnt_o        = gnt;
    assign lock_abort_o = abort;
    assign rvalid_o     = rvalid_q;
    assign rdata_o      = ram_rdata_i;

endmodule

// File: tb/tb_vrf_port_arbiter.sv
// Bench for vrf_port_arbiter: two instances (MaxLock 16 and 2) share stimulus,
// each with its own RAM and a cycle-level reference model.
module tb_vrf_port_arbiter;

    localparam int unsigned VLEN = 128;
    localparam int unsigned AW   = 5;
    localparam logic [127:0] A5  = {16{8'hA5}};

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [1:0]       req, we, lock;
    logic [AW-1:0]    a_arr [2];
    logic [VLEN-1:0]  d_arr [2];
    logic [2*AW-1:0]   addr_flat;
    logic [2*VLEN-1:0] wdata_flat;
    assign addr_flat  = {a_arr[1], a_arr[0]};
    assign wdata_flat = {d_arr[1], d_arr[0]};

    logic [1:0]      gnt_w [2];
    logic [1:0]      rvalid_w [2];
    logic [VLEN-1:0] rdata_w [2];
    logic            abort_w [2];
    logic            ram_req_w [2];
    logic            ram_we_w [2];
    logic [AW-1:0]   ram_addr_w [2];
    logic [VLEN-1:0] ram_wdata_w [2];
    logic [VLEN-1:0] ram_rdata_w [2];

    vrf_port_arbiter #(.VLEN(VLEN), .AddrWidth(AW), .MaxLock(16)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .lock_i(lock),
        .addr_i(addr_flat), .wdata_i(wdata_flat), .gnt_o(gnt_w[0]),
        .rvalid_o(rvalid_w[0]), .rdata_o(rdata_w[0]), .lock_abort_o(abort_w[0]),
        .ram_req_o(ram_req_w[0]), .ram_we_o(ram_we_w[0]), .ram_addr_o(ram_addr_w[0]),
        .ram_wdata_o(ram_wdata_w[0]), .ram_rdata_i(ram_rdata_w[0])
    );

    vrf_port_arbiter #(.VLEN(VLEN), .AddrWidth(AW), .MaxLock(2)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .lock_i(lock),
        .addr_i(addr_flat), .wdata_i(wdata_flat), .gnt_o(gnt_w[1]),
        .rvalid_o(rvalid_w[1]), .rdata_o(rdata_w[1]), .lock_abort_o(abort_w[1]),
        .ram_req_o(ram_req_w[1]), .ram_we_o(ram_we_w[1]), .ram_addr_o(ram_addr_w[1]),
        .ram_wdata_o(ram_wdata_w[1]), .ram_rdata_i(ram_rdata_w[1])
    );

    function automatic logic [127:0] pat(input int i);
        return {4{32'h1000_0000 + 32'(i)}};
    endfunction

    // Behavioural single-port RAM per instance (registered read data).
    logic [VLEN-1:0] ram_mem [2][32];
    bit ram_filled = 1'b0;
    always @(posedge clk) begin
        if (!ram_filled) begin
            for (int k = 0; k < 2; k++)
                for (int i = 0; i < 32; i++)
                    ram_mem[k][i] <= pat(i);
            ram_filled <= 1'b1;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (ram_req_w[k]) begin
                    if (ram_we_w[k]) ram_mem[k][ram_addr_w[k]] <= ram_wdata_w[k];
                    else             ram_rdata_w[k] <= ram_mem[k][ram_addr_w[k]];
                end
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model state (per instance).
    int               maxl [2];
    bit               m_locked [2];
    int               m_owner [2], m_rr [2], m_cnt [2];
    logic [1:0]       m_rv [2];
    logic [VLEN-1:0]  m_rdexp [2];
    logic [VLEN-1:0]  m_mem [2][32];
    bit               n_locked [2];
    int               n_owner [2], n_rr [2], n_cnt [2];
    logic [1:0]       n_rv [2];
    logic [VLEN-1:0]  n_rdexp [2];
    bit               n_wr [2];
    int               n_wa [2];
    logic [VLEN-1:0]  n_wd [2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_locked[k] = 1'b0; m_owner[k] = 0; m_rr[k] = 0; m_cnt[k] = 0;
            m_rv[k] = 2'b00; n_wr[k] = 1'b0;
        end
    endtask

    // Compare process: predict each cycle from the arbitration rules, check, then commit.
    initial begin
        bit have_next;
        maxl[0] = 16;
        maxl[1] = 2;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 32; i++)
                m_mem[k][i] = pat(i);
        model_reset();
        forever begin
            @(negedge clk);
            have_next = 1'b0;
            if (!rst_n) begin
                model_reset();
                for (int k = 0; k < 2; k++) begin
                    chk($sformatf("u%0d reset gnt", k), 128'(gnt_w[k]), 128'(0));
                    chk($sformatf("u%0d reset rvalid", k), 128'(rvalid_w[k]), 128'(0));
                    chk($sformatf("u%0d reset abort", k), 128'(abort_w[k]), 128'(0));
                end
            end else begin
                for (int k = 0; k < 2; k++) begin
                    int win, pref, o, x, sel;
                    bit arb, eab;
                    logic [1:0] eg;
                    n_locked[k] = m_locked[k]; n_owner[k] = m_owner[k];
                    n_rr[k] = m_rr[k]; n_cnt[k] = m_cnt[k];
                    n_wr[k] = 1'b0; n_rv[k] = 2'b00; n_rdexp[k] = '0;
                    eg = 2'b00; eab = 1'b0; win = -1; arb = 1'b0; pref = m_rr[k];
                    if (!m_locked[k]) begin
                        arb = 1'b1;
                    end else begin
                        o = m_owner[k];
                        x = 1 - o;
                        if (!req[o]) begin
                            arb = 1'b1; pref = x; n_locked[k] = 1'b0;
                        end else if (maxl[k] != 0 && m_cnt[k] >= maxl[k] && req[x]) begin
                            win = x; eab = 1'b1; n_rr[k] = o; n_locked[k] = 1'b0;
                        end else begin
                            win = o;
                            if (lock[o]) begin
                                if (req[x] && m_cnt[k] < maxl[k]) n_cnt[k] = m_cnt[k] + 1;
                            end else begin
                                n_rr[k] = x; n_locked[k] = 1'b0;
                            end
                        end
                    end
                    if (arb && req != 2'b00) begin
                        win = (req == 2'b11) ? pref : (req[1] ? 1 : 0);
                        if (lock[win]) begin
                            n_locked[k] = 1'b1; n_owner[k] = win; n_cnt[k] = 0;
                        end else begin
                            n_rr[k] = 1 - win; n_locked[k] = 1'b0;
                        end
                    end
                    if (win >= 0) eg[win] = 1'b1;
                    sel = (win >= 0) ? win : 0;

                    chk($sformatf("u%0d gnt", k), 128'(gnt_w[k]), 128'(eg));
                    chk($sformatf("u%0d abort", k), 128'(abort_w[k]), 128'(eab));
                    chk($sformatf("u%0d ram_req", k), 128'(ram_req_w[k]), 128'(win >= 0));
                    chk($sformatf("u%0d ram_we", k), 128'(ram_we_w[k]), 128'((win >= 0) && we[sel]));
                    chk($sformatf("u%0d ram_addr", k), 128'(ram_addr_w[k]),
                        (win >= 0) ? 128'(a_arr[sel]) : 128'(0));
                    chk($sformatf("u%0d ram_wdata", k), 128'(ram_wdata_w[k]),
                        (win >= 0) ? 128'(d_arr[sel]) : 128'(0));
                    chk($sformatf("u%0d rvalid", k), 128'(rvalid_w[k]), 128'(m_rv[k]));
                    if (m_rv[k] != 2'b00)
                        chk($sformatf("u%0d rdata", k), 128'(rdata_w[k]), 128'(m_rdexp[k]));

                    if (win >= 0) begin
                        if (we[win]) begin
                            n_wr[k] = 1'b1; n_wa[k] = int'(a_arr[win]); n_wd[k] = d_arr[win];
                        end else begin
                            n_rv[k] = eg; n_rdexp[k] = m_mem[k][a_arr[win]];
                        end
                    end
                end
                have_next = 1'b1;
            end
            @(posedge clk);
            if (!rst_n) begin
                model_reset();
            end else if (have_next) begin
                for (int k = 0; k < 2; k++) begin
                    m_locked[k] = n_locked[k]; m_owner[k] = n_owner[k];
                    m_rr[k] = n_rr[k]; m_cnt[k] = n_cnt[k];
                    m_rv[k] = n_rv[k]; m_rdexp[k] = n_rdexp[k];
                    if (n_wr[k]) m_mem[k][n_wa[k]] = n_wd[k];
                end
            end
        end
    end

    task automatic set_in(input logic [1:0] r, input logic [1:0] w, input logic [1:0] l,
                          input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                          input logic [VLEN-1:0] d0, input logic [VLEN-1:0] d1);
        req = r; we = w; lock = l;
        a_arr[0] = a0; a_arr[1] = a1; d_arr[0] = d0; d_arr[1] = d1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        set_in(2'b00, 2'b00, 2'b00, 5'd0, 5'd0, '0, '0);
    endtask

    task automatic lit_gnt(input string nm, input int k, input logic [1:0] g, input logic ab);
        chk($sformatf("%s u%0d gnt", nm, k), 128'(gnt_w[k]), 128'(g));
        chk($sformatf("%s u%0d abort", nm, k), 128'(abort_w[k]), 128'(ab));
    endtask

    // Directed stimulus with hand-computed expectations.
    initial begin
        rst_n = 1'b0;
        idle();
        repeat (3) step();
        @(negedge clk);
        chk("post-reset rvalid u0", 128'(rvalid_w[0]), 128'(0));
        chk("post-reset gnt u1", 128'(gnt_w[1]), 128'(0));
        step();
        rst_n = 1'b1;

        // Single read by port 0: same-cycle grant, data one cycle later.
        set_in(2'b01, 2'b00, 2'b00, 5'd3, 5'd0, '0, '0);
        @(negedge clk);
        lit_gnt("t1", 0, 2'b01, 1'b0);
        chk("t1 ram_addr", 128'(ram_addr_w[0]), 128'(3));
        step();
        idle();
        @(negedge clk);
        chk("t1 rvalid", 128'(rvalid_w[0]), 128'(2'b01));
        chk("t1 rdata", rdata_w[0], pat(3));
        step();

        // Port 1 alone moves the pointer back to port 0.
        set_in(2'b10, 2'b00, 2'b00, 5'd0, 5'd4, '0, '0);
        step();

        // Round robin with both requesting.
        set_in(2'b11, 2'b00, 2'b00, 5'd1, 5'd2, '0, '0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            lit_gnt($sformatf("t2 c%0d", i), 0, (i % 2 == 0) ? 2'b01 : 2'b10, 1'b0);
            lit_gnt($sformatf("t2 c%0d", i), 1, (i % 2 == 0) ? 2'b01 : 2'b10, 1'b0);
            step();
        end

        // Port 0 alone gives port 1 priority.
        set_in(2'b01, 2'b00, 2'b00, 5'd6, 5'd0, '0, '0);
        step();

        // Port 1 locked burst of four beats while port 0 waits.
        set_in(2'b11, 2'b00, 2'b10, 5'd5, 5'd8, '0, '0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            lit_gnt($sformatf("t3 c%0d", i), 0, 2'b10, 1'b0);
            step();
        end
        set_in(2'b11, 2'b00, 2'b00, 5'd5, 5'd8, '0, '0);
        @(negedge clk);
        lit_gnt("t3 last", 0, 2'b10, 1'b0);
        step();
        set_in(2'b01, 2'b00, 2'b00, 5'd5, 5'd8, '0, '0);
        @(negedge clk);
        lit_gnt("t3 after", 0, 2'b01, 1'b0);
        step();
        idle();
        step();

        set_in(2'b10, 2'b00, 2'b00, 5'd0, 5'd9, '0, '0);
        step();

        // Port 0 holds lock; MaxLock=2 instance force-releases on the fourth cycle.
        set_in(2'b11, 2'b00, 2'b01, 5'd10, 5'd11, '0, '0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            lit_gnt($sformatf("t4 c%0d", i), 1, (i < 3) ? 2'b01 : 2'b10, (i == 3));
            lit_gnt($sformatf("t4 c%0d", i), 0, 2'b01, 1'b0);
            step();
        end
        set_in(2'b01, 2'b00, 2'b00, 5'd10, 5'd11, '0, '0);
        step();
        idle();
        step();

        // Locked owner drops its request: the other port is granted at once.
        set_in(2'b01, 2'b00, 2'b01, 5'd12, 5'd0, '0, '0);
        step();
        set_in(2'b10, 2'b00, 2'b00, 5'd0, 5'd13, '0, '0);
        @(negedge clk);
        lit_gnt("t5", 0, 2'b10, 1'b0);
        lit_gnt("t5", 1, 2'b10, 1'b0);
        step();
        idle();
        step();

        // Write by port 0, read back by port 1.
        set_in(2'b01, 2'b01, 2'b00, 5'd7, 5'd0, A5, '0);
        @(negedge clk);
        lit_gnt("t6 wr", 0, 2'b01, 1'b0);
        chk("t6 ram_we", 128'(ram_we_w[0]), 128'(1));
        chk("t6 ram_wdata", ram_wdata_w[0], A5);
        step();
        set_in(2'b10, 2'b00, 2'b00, 5'd0, 5'd7, '0, '0);
        @(negedge clk);
        lit_gnt("t6 rd", 0, 2'b10, 1'b0);
        step();
        idle();
        @(negedge clk);
        chk("t6 rvalid", 128'(rvalid_w[0]), 128'(2'b10));
        chk("t6 rdata", rdata_w[0], A5);
        step();

        // Reset in the middle of a locked read burst.
        set_in(2'b10, 2'b00, 2'b10, 5'd0, 5'd7, '0, '0);
        step();
        step();
        rst_n = 1'b0;
        idle();
        @(negedge clk);
        chk("t6 rst rvalid u0", 128'(rvalid_w[0]), 128'(0));
        chk("t6 rst rvalid u1", 128'(rvalid_w[1]), 128'(0));
        step();
        step();
        rst_n = 1'b1;
        set_in(2'b11, 2'b00, 2'b00, 5'd1, 5'd2, '0, '0);
        @(negedge clk);
        lit_gnt("t6 post-rst", 0, 2'b01, 1'b0);
        lit_gnt("t6 post-rst", 1, 2'b01, 1'b0);
        step();
        idle();
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
